program_loader: RTL and testbench

Writes a program image into the instruction memory, which the fetch path otherwise only reads combinationally through byte addresses. A big-endian byte stream with a valid/ready handshake carries a 16-bit word count followed by the instruction words, most-significant byte first. The loader assembles the bytes into 32-bit words and issues one write per word, at word-aligned byte addresses starting at 0. While a load is in progress it holds the processor in reset.

---
 rtl/loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 35 +++
 rtl/program_loader.sv | 127 ++++++++++++
 tb/tb_program_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states and stream framing constants.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        BYTE,
        WRITE,
        DONE
    } state_t;

    // Length header is a big-endian 16-bit word count.
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned LEN_BITS       = LEN_BYTES * 8;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Shifts stream bytes MSB-first into an instruction word and flags the byte that completes it.
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    logic [1:0] count;

    // The byte shifted in this cycle is the last one of the word.
    assign word_done = shift && (count == 2'(BYTES_PER_WORD - 1));

    // Shift register and byte counter; the counter wraps back to 0 after each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (shift) begin
            word  <= {word[WIDTH-9:0], byte_in};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory while holding the CPU in reset.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error
);

    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));
    localparam logic [DATA_WIDTH-1:0] ADDR_STEP = DATA_WIDTH'(BYTES_PER_WORD);

    state_t              state;
    logic [7:0]          len_hi;
    logic [LEN_BITS-1:0] len_word;
    logic [LEN_BITS-1:0] remaining;
    logic                xfer;
    logic                word_done;

    assign xfer     = ByteValid && ByteReady;
    assign len_word = {len_hi, ByteIn};

    word_assembler #(
        .WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk       (clk),
        .rst_n     (reset),
        .clear     ((state == IDLE) && Start),
        .shift     (xfer && (state == BYTE)),
        .byte_in   (ByteIn),
        .word      (WriteData),
        .word_done (word_done)
    );

    // Load sequencer; outputs are registered from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len_hi       <= '0;
            remaining    <= '0;
            ByteReady    <= 1'b0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            CpuHold      <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            Done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state        <= LEN_HI;
                        ByteReady    <= 1'b1;
                        CpuHold      <= 1'b1;
                        Error        <= 1'b0;
                        WriteAddress <= '0;
                        remaining    <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= ByteIn;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        remaining <= len_word;
                        if (len_word == '0 || 32'(len_word) > 32'(MEMORY_DEPTH)) begin
                            state     <= DONE;
                            ByteReady <= 1'b0;
                            Done      <= 1'b1;
                            CpuHold   <= 1'b0;
                            Error     <= (len_word != '0);
                        end else begin
                            state <= BYTE;
                        end
                    end
                end
                BYTE: begin
                    if (word_done) begin
                        state       <= WRITE;
                        ByteReady   <= 1'b0;
                        WriteEnable <= 1'b1;
                    end
                end
                WRITE: begin
                    remaining <= remaining - 1'b1;
                    // Hold at the last word address so a full-depth load never points past memory.
                    if (WriteAddress != LAST_ADDR) begin
                        WriteAddress <= WriteAddress + ADDR_STEP;
                    end
                    if (remaining == LEN_BITS'(1)) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        CpuHold <= 1'b0;
                    end else begin
                        state     <= BYTE;
                        ByteReady <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    ByteReady <= 1'b0;
                    CpuHold   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a queue-based model of the expected memory writes.
module tb_program_loader;

    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    always #5 clk = ~clk;

    program_loader #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .Start        (Start),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .CpuHold      (CpuHold),
        .Done         (Done),
        .Error        (Error)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nwrites = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next write the model predicts.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (WriteEnable) begin
            nwrites++;
            last_addr = WriteAddress;
            check("cpuhold_in_write", 32'(CpuHold), 32'd1);
            if (exp_addr_q.size() == 0) begin
                check("extra_write", 32'd1, 32'd0);
            end else begin
                check("waddr", WriteAddress, exp_addr_q.pop_front());
                check("wdata", WriteData, exp_data_q.pop_front());
            end
        end
    end

    // One full load: model predicts writes/error, then the stream is driven with optional gaps.
    task automatic run_load(input logic [15:0] count, input logic [31:0] words[$],
                            input bit gaps, output int lat);
        logic [7:0] bytes[$];
        int         ready_cyc;
        int         idx;
        int         guard;
        bit         exp_err;
        bytes.push_back(count[15:8]);
        bytes.push_back(count[7:0]);
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) bytes.push_back(8'(words[i] >> (8 * b)));
        end
        exp_err = (32'(count) > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < int'(count); i++) begin
                exp_addr_q.push_back(32'(4 * i));
                exp_data_q.push_back(words[i]);
            end
        end
        nwrites = 0;

        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
        check("start_hold", 32'(CpuHold), 32'd1);
        check("start_ready", 32'(ByteReady), 32'd1);
        check("start_err_clr", 32'(Error), 32'd0);
        ready_cyc = cyc;

        idx = 0;
        guard = 0;
        while (idx < bytes.size() && guard < 4000) begin
            ByteValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ByteIn    = bytes[idx];
            if (gaps && idx > 2 && ((idx - 2) % 4) != 0)
                check("ready_mid_word", 32'(ByteReady), 32'd1);
            if (ByteValid && ByteReady) idx++;
            @(negedge clk);
            guard++;
        end
        ByteValid = 1'b0;
        if (guard >= 4000) check("byte_timeout", 32'd0, 32'd1);

        guard = 0;
        while (!Done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 32'(Done), 32'd1);
        lat = cyc - ready_cyc + 1;
        check("cpuhold_at_done", 32'(CpuHold), 32'd0);
        check("error", 32'(Error), 32'(exp_err));
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);
        check("write_count", 32'(nwrites), exp_err ? 32'd0 : 32'(count));

        @(negedge clk);
        check("done_pulse", 32'(Done), 32'd0);
        check("idle_ready", 32'(ByteReady), 32'd0);
        check("error_sticky", 32'(Error), 32'(exp_err));
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] none[$];
        int          lat;
        int          n;
        bit          g;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ByteReady), 32'd0);
        check("rst_we", 32'(WriteEnable), 32'd0);
        check("rst_addr", WriteAddress, 32'd0);
        check("rst_data", WriteData, 32'd0);
        check("rst_hold", 32'(CpuHold), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word reference load.
        w = '{32'h20080005, 32'h01095020};
        run_load(16'd2, w, 1'b0, lat);
        check("latency_2w", 32'(lat), 32'd13);

        // Empty image.
        run_load(16'd0, none, 1'b0, lat);
        check("latency_0w", 32'(lat), 32'd3);

        // Oversized count; the next load's start checks Error clears.
        run_load(16'h0021, none, 1'b0, lat);
        check("latency_err", 32'(lat), 32'd3);

        // Full-depth load.
        w.delete();
        for (int i = 0; i < int'(DEPTH); i++) w.push_back($urandom);
        run_load(16'(DEPTH), w, 1'b0, lat);
        check("last_addr", last_addr, 32'h7C);
        check("latency_full", 32'(lat), 32'(3 + 5 * DEPTH));

        // Same 3-word image with and without stream gaps.
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_load(16'd3, w, 1'b0, lat);
        check("latency_3w", 32'(lat), 32'd18);
        run_load(16'd3, w, 1'b1, lat);

        // Reset in the middle of a word, then a clean reload.
        nwrites = 0;
        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
        w = '{32'h000001AA, 32'h000000BB};
        for (int i = 0; i < 4; i++) begin
            ByteValid = 1'b1;
            ByteIn    = (i < 2) ? ((i == 0) ? 8'h00 : 8'h01) : ((i == 2) ? 8'hAA : 8'hBB);
            @(negedge clk);
        end
        ByteValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ByteReady), 32'd0);
        check("arst_hold", 32'(CpuHold), 32'd0);
        check("arst_data", WriteData, 32'd0);
        check("arst_we", 32'(WriteEnable), 32'd0);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_error", 32'(Error), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_write", 32'(nwrites), 32'd0);
        w = '{32'hDEADBEEF};
        run_load(16'd1, w, 1'b0, lat);
        check("latency_1w", 32'(lat), 32'd8);

        // Random images, random gaps.
        repeat (6) begin
            n = int'($urandom_range(1, 6));
            g = 1'($urandom_range(0, 1));
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_load(16'(n), w, g, lat);
            if (!g) check("latency_rand", 32'(lat), 32'(3 + 5 * n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
